// File: rtl/decoder_lane_arbiter.sv
// Round-robin burst arbiter merging NUM_LANES decoder FIFO lanes onto one registered
// AXI-Stream output; each grant lasts up to MAX_BURST beats and beats carry their lane index.
module decoder_lane_arbiter #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DWIDTH    = 64,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned LW = ($clog2(NUM_LANES) > 1) ? $clog2(NUM_LANES) : 1,
  localparam int unsigned BW = ($clog2(MAX_BURST) > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                          aclk,
  input  logic                          rst,
  input  logic [NUM_LANES-1:0]          lane_enable,
  input  logic [NUM_LANES*DWIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_LANES-1:0]          s_axis_tvalid,
  output logic [NUM_LANES-1:0]          s_axis_tready,
  output logic [DWIDTH-1:0]             m_axis_tdata,
  output logic [LW-1:0]                 m_axis_tdest,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [NUM_LANES-1:0]          grant_onehot
);

  localparam logic [LW:0]   NumLanesW = (LW + 1)'(NUM_LANES);
  localparam logic [LW-1:0] LastLane  = LW'(NUM_LANES - 1);
  localparam logic [BW-1:0] LastBeat  = BW'(MAX_BURST - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q;
  logic [LW-1:0]     rr_ptr_q;
  logic [LW-1:0]     grant_idx_q;
  logic [BW-1:0]     burst_cnt_q;

  logic [NUM_LANES-1:0] req;
  logic                 out_rdy;
  logic                 xfer;
  logic                 release_grant;
  logic                 sel_found;
  logic [LW-1:0]        sel_idx;
  logic [LW-1:0]        next_ptr;
  logic [LW:0]          scan_sum;
  logic [DWIDTH-1:0]    lane_data [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_data
    assign lane_data[g] = s_axis_tdata[g*DWIDTH +: DWIDTH];
  end

  assign req     = s_axis_tvalid & lane_enable;
  assign out_rdy = ~m_axis_tvalid | m_axis_tready;

  // First requesting lane at or after rr_ptr; the sum is folded so it never exceeds NUM_LANES-1.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_sum  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (LW + 1)'(i);
      if (scan_sum >= NumLanesW) begin
        scan_sum = scan_sum - NumLanesW;
      end
      if (!sel_found && req[scan_sum[LW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = scan_sum[LW-1:0];
      end
    end
  end

  assign next_ptr = (grant_idx_q == LastLane) ? '0 : grant_idx_q + 1'b1;

  // Ready ignores the lane's own tvalid; gated by rst so nothing is accepted in a reset cycle.
  always_comb begin
    s_axis_tready = '0;
    if (state_q == StGrant && !rst) begin
      s_axis_tready[grant_idx_q] = out_rdy & lane_enable[grant_idx_q];
    end
  end

  assign xfer = (state_q == StGrant) && s_axis_tvalid[grant_idx_q] && s_axis_tready[grant_idx_q];

  assign release_grant = (xfer && (burst_cnt_q == LastBeat)) ||
                         !s_axis_tvalid[grant_idx_q] || !lane_enable[grant_idx_q];

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      grant_idx_q   <= '0;
      burst_cnt_q   <= '0;
      grant_onehot  <= '0;
      m_axis_tdata  <= '0;
      m_axis_tdest  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (xfer) begin
        m_axis_tdata  <= lane_data[grant_idx_q];
        m_axis_tdest  <= grant_idx_q;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (sel_found) begin
            grant_idx_q  <= sel_idx;
            burst_cnt_q  <= '0;
            grant_onehot <= NUM_LANES'(1) << sel_idx;
            state_q      <= StGrant;
          end
        end
        StGrant: begin
          if (xfer) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
          end
          if (release_grant) begin
            state_q      <= StIdle;
            rr_ptr_q     <= next_ptr;
            grant_onehot <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/decoder_lane_arbiter.md
# decoder_lane_arbiter

Round-robin burst arbiter that merges the output streams of NUM_LANES decoder FIFO lanes onto one AXI-Stream bus in the traffic engine decoder. It sits on the consumer-clock side, downstream of the per-lane width-converting FIFOs. It grants one lane at a time for up to MAX_BURST beats, tags each beat with its lane index, and skips lanes masked off by configuration. The output is registered.

## Interface
- NUM_LANES, 4, number of input lanes (2..16, need not be a power of 2)
- DWIDTH, 64, data width per lane and at output
- MAX_BURST, 16, maximum beats per grant (>=1)
- LW = max(1, $clog2(NUM_LANES)); BW = max(1, $clog2(MAX_BURST)) (derived localparams)

Ports:
- aclk  in  1  single clock for the block
- rst  in  1  synchronous, active-high reset
- lane_enable  in  NUM_LANES  per-lane enable mask; a disabled lane is never granted
- s_axis_tdata  in  NUM_LANES*DWIDTH  lane i occupies bits [i*DWIDTH +: DWIDTH]
- s_axis_tvalid  in  NUM_LANES  per-lane valid
- s_axis_tready  out  NUM_LANES  per-lane ready; at most one bit is high
- m_axis_tdata  out  DWIDTH  registered output data
- m_axis_tdest  out  LW  lane index of the current output beat
- m_axis_tvalid  out  1  registered output valid
- m_axis_tready  in  1  downstream ready
- grant_onehot  out  NUM_LANES  currently granted lane; all zero in IDLE

## Operation
- Definitions:
  - req = s_axis_tvalid & lane_enable
  - out_rdy = ~m_axis_tvalid | m_axis_tready
- State machine has two states, IDLE and GRANT.
- IDLE:
  - All s_axis_tready bits are 0.
  - If req != 0, select the first set bit of req at or after rr_ptr, scanning upward and wrapping from NUM_LANES-1 to 0.
  - On selection: grant_idx <= selected lane, burst_cnt <= 0, go to GRANT.
  - If req == 0, stay in IDLE.
- GRANT:
  - s_axis_tready[grant_idx] = out_rdy & lane_enable[grant_idx]. All other ready bits are 0.
  - On a transfer (tvalid & tready on the granted lane):
    - m_axis_tdata <= lane data
    - m_axis_tdest <= grant_idx
    - m_axis_tvalid <= 1
    - burst_cnt <= burst_cnt + 1
  - If there is no new transfer and m_axis_tready is high, m_axis_tvalid <= 0.
- Release conditions. Any one of these returns the FSM to IDLE at the end of the cycle and sets rr_ptr <= (grant_idx + 1) mod NUM_LANES:
  - a transfer occurs while burst_cnt == MAX_BURST-1 (the burst limit);
  - s_axis_tvalid[grant_idx] == 0 (the lane has run dry);
  - lane_enable[grant_idx] == 0 (mid-burst disable; no transfer happens in that cycle).
- Precedence and arithmetic:
  - A stalled output (out_rdy = 0) with the granted lane's valid still high is not a release condition. The grant is held.
  - rr_ptr wraps with explicit modulo arithmetic; it never indexes past NUM_LANES-1 for non-power-of-2 NUM_LANES.
  - MAX_BURST = 1: every transfer releases the grant.
- grant_onehot = (state == GRANT) ? (1 << grant_idx) : 0.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0, grant_idx = 0, burst_cnt = 0
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tdest = 0
  - s_axis_tready = 0, grant_onehot = 0
- Reset asserted mid-burst: any beat held in the output register is discarded, and no input handshake occurs in the reset cycle.
- Arbitration costs one cycle (IDLE) per grant. The first s_axis_tready of a grant rises in the cycle after the request is seen.
- Data latency: an input handshake in cycle N produces m_axis_tvalid with that data in cycle N+1.
- Throughput:
  - Sustained, with all lanes always valid: MAX_BURST beats per MAX_BURST+1 cycles.
  - Within a grant with no output stall: one beat per cycle.
- m_axis_tdata, m_axis_tdest and m_axis_tvalid stay stable while m_axis_tvalid = 1 and m_axis_tready = 0.
- Input ready never depends combinationally on its own lane's s_axis_tvalid.
- lane_enable changes take effect in the same cycle. Deassertion during GRANT blocks that cycle's transfer, and the arbiter releases to IDLE.

## Test plan
- NUM_LANES=4, MAX_BURST=4, all lanes enabled and continuously valid, m_axis_tready=1:
  - m_axis_tdest sequence is 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...
  - There is exactly one m_axis_tvalid=0 bubble per 4 beats.
  - No beat is lost or duplicated; lane data is an incrementing counter per lane, checked per lane.
- Only lane 2 valid, for 2 beats then dry:
  - 2 beats out with tdest=2, then release to IDLE.
  - The next grant, with lanes 0 and 3 requesting, goes to lane 3 (rr_ptr=3).
- m_axis_tready toggled randomly (about 50%) under full load:
  - Output data/tdest stay stable while stalled.
  - Each burst length equals exactly MAX_BURST.
  - Per-lane order is preserved.
- lane_enable[1] cleared at the 2nd beat of lane 1's burst:
  - That cycle's s_axis_tready[1]=0 and the grant is released.
  - Lane 1 is never granted while disabled, even if it is the only valid lane.
- NUM_LANES=3, MAX_BURST=1, all lanes valid:
  - tdest pattern is 0,1,2,0,1,2 with a bubble between beats.
  - rr_ptr wraps from 2 to 0 with no out-of-range index.
- rst asserted mid-burst while m_axis_tvalid=1:
  - All outputs return to their reset values the next cycle.
  - After deassertion, arbitration restarts at lane 0.
